// File: rtl/cpu_board_pkg.sv
// Shared types and constants for the CPU board clock-enable logic.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_board_pkg;

    typedef enum logic {
        ST_STEP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] SPD_SLOW = 2'd0;
    localparam logic [1:0] SPD_MED  = 2'd1;
    localparam logic [1:0] SPD_FAST = 2'd2;
    localparam logic [1:0] SPD_FULL = 2'd3;

    // Each faster speed drops this many high prescaler bits from its terminal match.
    localparam int SPD_SHIFT_MED  = 4;
    localparam int SPD_SHIFT_FAST = 8;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counter debounce and one-cycle press pulse for a raw button.
// Latency: press fires DEBOUNCE_CYCLES+3 cycles after a clean rising input.
// Backpressure: none; release edges produce no pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync0;
    logic          sync1;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync0    <= btn;
            sync1    <= sync0;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            // Any return to the accepted level restarts the stability window.
            if (sync1 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync1;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Single-clock CPU step enable: manual single-step or prescaled free-run pulses on cpu_ce.
// Latency: cpu_ce one cycle after a step press; first RUN pulse one cycle after entering RUN.
// Backpressure: none; halt forces STEP and suppresses any pending RUN pulse.
module cpu_step_ctrl
    import cpu_board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DIV_WIDTH       = 28,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_step,
    input  logic                 btn_run,
    input  logic [1:0]           speed,
    input  logic                 halt,
    output logic                 cpu_ce,
    output logic                 run_mode,
    output logic [CNT_WIDTH-1:0] step_count
);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 step_press;
    logic                 run_press;
    logic                 terminal;
    logic [DIV_WIDTH-1:0] presc;
    state_t               state;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_step),
        .press (step_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_run),
        .press (run_press)
    );

    // speed is read live so a switch change lands on the next matching count.
    always_comb begin
        terminal = 1'b1;
        case (speed)
            SPD_SLOW: terminal = &presc;
            SPD_MED:  terminal = &presc[DIV_WIDTH-SPD_SHIFT_MED-1:0];
            SPD_FAST: terminal = &presc[DIV_WIDTH-SPD_SHIFT_FAST-1:0];
            default:  terminal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_STEP;
            presc      <= '0;
            cpu_ce     <= 1'b0;
            step_count <= '0;
        end else begin
            if (cpu_ce) begin
                step_count <= step_count + CNT_ONE;
            end
            case (state)
                ST_STEP: begin
                    presc  <= '0;
                    cpu_ce <= step_press & ~run_press;
                    if (run_press && !halt) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (run_press || halt) begin
                        state  <= ST_STEP;
                        presc  <= '0;
                        cpu_ce <= 1'b0;
                    end else begin
                        presc  <= presc + DIV_ONE;
                        cpu_ce <= terminal;
                    end
                end
                default: begin
                    state  <= ST_STEP;
                    presc  <= '0;
                    cpu_ce <= 1'b0;
                end
            endcase
        end
    end

    assign run_mode = (state == ST_RUN);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4, DIV_WIDTH=12.
// Stimulus queues the cycle and pre-pulse count of every expected cpu_ce pulse.
module tb_cpu_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_step = 1'b0;
    logic        btn_run = 1'b0;
    logic [1:0]  speed = 2'd3;
    logic        halt = 1'b0;
    logic        cpu_ce;
    logic        run_mode;
    logic [15:0] step_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mcnt = 16'd0;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DIV_WIDTH      (12),
        .CNT_WIDTH      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_step   (btn_step),
        .btn_run    (btn_run),
        .speed      (speed),
        .halt       (halt),
        .cpu_ce     (cpu_ce),
        .run_mode   (run_mode),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every observed pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (cpu_ce === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL pulse: unexpected cpu_ce at cycle %0d (count %0h), none expected", cyc, step_count);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || step_count !== e.cnt) begin
                    errors++;
                    $display("FAIL pulse: got cycle %0d count %0h, want cycle %0d count %0h",
                             cyc, step_count, e.cyc, e.cnt);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_range(input int a, input int b);
        for (int c = a; c <= b; c++) begin
            exp_t e;
            e.cyc = c;
            e.cnt = mcnt;
            q.push_back(e);
            mcnt = mcnt + 16'd1;
        end
    endtask

    task automatic press_run();
        btn_run = 1'b1;
        tick(10);
        btn_run = 1'b0;
    endtask

    initial begin
        int n;
        int k;

        tick(3);
        chk("reset_ce", {31'd0, cpu_ce}, 32'd0);
        chk("reset_run_mode", {31'd0, run_mode}, 32'd0);
        chk("reset_count", {16'd0, step_count}, 32'd0);
        rst = 1'b0;
        tick(3);

        // Glitch of 3 cycles is one short of the debounce window.
        btn_step = 1'b1;
        tick(3);
        btn_step = 1'b0;
        tick(15);
        chk("glitch_count", {16'd0, step_count}, 32'd0);

        // Held step button: pulse 8 cycles after the driving edge.
        n = cyc;
        push_range(n + 8, n + 8);
        btn_step = 1'b1;
        tick(10);
        btn_step = 1'b0;
        tick(12);
        chk("step_count", {16'd0, step_count}, 32'd1);
        chk("step_run_mode", {31'd0, run_mode}, 32'd0);

        // Full-rate run, stopped by a second press at n+30.
        speed = 2'd3;
        n = cyc;
        push_range(n + 9, n + 37);
        press_run();
        wait_cyc(n + 30);
        chk("full_run_mode", {31'd0, run_mode}, 32'd1);
        press_run();
        tick(12);
        chk("full_stop_mode", {31'd0, run_mode}, 32'd0);
        chk("full_count", {16'd0, step_count}, 32'd30);

        // Speed 2 period 16, then switch to speed 1 mid-run.
        speed = 2'd2;
        n = cyc;
        push_range(n + 24, n + 24);
        push_range(n + 40, n + 40);
        push_range(n + 56, n + 56);
        push_range(n + 72, n + 72);
        push_range(n + 264, n + 264);
        press_run();
        wait_cyc(n + 75);
        speed = 2'd1;
        chk("slow_count_4", {16'd0, step_count}, 32'd34);
        wait_cyc(n + 100);
        chk("slow_run_mode", {31'd0, run_mode}, 32'd1);
        chk("slow_count_held", {16'd0, step_count}, 32'd34);
        wait_cyc(n + 270);
        press_run();
        tick(12);
        chk("slow_stop_mode", {31'd0, run_mode}, 32'd0);
        chk("slow_count", {16'd0, step_count}, 32'd35);

        // Halt during full-rate run, then run press while halted.
        speed = 2'd3;
        n = cyc;
        push_range(n + 9, n + 20);
        press_run();
        wait_cyc(n + 20);
        halt = 1'b1;
        tick(1);
        chk("halt_run_mode", {31'd0, run_mode}, 32'd0);
        chk("halt_ce", {31'd0, cpu_ce}, 32'd0);
        wait_cyc(n + 25);
        press_run();
        tick(12);
        chk("halt_press_mode", {31'd0, run_mode}, 32'd0);
        chk("halt_count", {16'd0, step_count}, 32'd47);
        halt = 1'b0;

        // Fill the counter to all ones, then one step wraps it.
        n = cyc;
        k = 32'hFFFF - int'(mcnt);
        push_range(n + 9, n + 8 + k);
        press_run();
        wait_cyc(n + 8 + k);
        halt = 1'b1;
        tick(2);
        halt = 1'b0;
        chk("prewrap_count", {16'd0, step_count}, 32'h0000FFFF);
        chk("prewrap_mode", {31'd0, run_mode}, 32'd0);
        n = cyc;
        push_range(n + 8, n + 8);
        btn_step = 1'b1;
        tick(10);
        btn_step = 1'b0;
        tick(12);
        chk("wrap_count", {16'd0, step_count}, 32'd0);

        // Reset asserted in the middle of a run.
        n = cyc;
        push_range(n + 9, n + 20);
        press_run();
        wait_cyc(n + 20);
        rst = 1'b1;
        tick(1);
        chk("midrst_ce", {31'd0, cpu_ce}, 32'd0);
        chk("midrst_mode", {31'd0, run_mode}, 32'd0);
        chk("midrst_count", {16'd0, step_count}, 32'd0);
        rst = 1'b0;
        mcnt = 16'd0;
        tick(1);
        chk("postrst_ce", {31'd0, cpu_ce}, 32'd0);
        tick(20);
        chk("postrst_mode", {31'd0, run_mode}, 32'd0);

        chk("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
